// File: rtl/alu_op_sequencer.sv
`timescale 1ns/1ps
// alu_op_sequencer: register-file front end that issues one instruction at a time to an external ALU and writes back its result.
// Latency: accept on edge N -> operands on alu_a/alu_b after N, ALU sampled at N+2, out_valid high after N+2 (first seen at edge N+3).
// Backpressure: single instruction in flight; in_ready only in IDLE, RESP holds until out_ready. Macro ALU_SEQ_FLAGS_EN adds flag capture.
module alu_op_sequencer #(
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  // instruction handshake
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic [REG_AW-1:0] in_rs2,
  // register preload
  input  logic              ld_en,
  input  logic [REG_AW-1:0] ld_addr,
  input  logic [15:0]       ld_data,
  // ALU drive
  output logic [15:0]       alu_a,
  output logic [15:0]       alu_b,
  output logic [2:0]        alu_op,
  // ALU return: bit0 add/sub unit, bit1 bitwise unit, bit2 shift unit
  input  logic [15:0]       alu_c,
  input  logic [2:0]        alu_cout,
  input  logic [2:0]        alu_overflow,
  input  logic [2:0]        alu_negative,
  input  logic [2:0]        alu_zero,
  // response
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_result,
  output logic [3:0]        out_flags,
  output logic              busy
);

  localparam int NREG = 1 << REG_AW;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_EXEC  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e state_q, state_d;

  // FSM-decoded controls
  logic accept;
  logic cap_en;

  // register file and its single write port
  logic [15:0]       rf_q [NREG];
  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [15:0]       rf_wdata;

  // operand fetch values (entry 0 is forced to zero on read as well as never written)
  logic [15:0] rd_a, rd_b;

  // issued instruction
  logic [15:0]       alu_a_q, alu_b_q;
  logic [2:0]        alu_op_q;
  logic [REG_AW-1:0] rd_q;
  logic [15:0]       result_q;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: ISSUE and EXEC last one cycle each, RESP waits for out_ready
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = S_ISSUE;
      S_ISSUE: state_d = S_EXEC;
      S_EXEC:  state_d = S_RESP;
      S_RESP:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: handshake, status and the EXEC capture strobe
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    cap_en    = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      S_EXEC:  cap_en    = 1'b1;
      S_RESP:  out_valid = 1'b1;
      default: ;
    endcase
  end

  assign accept = in_valid & in_ready;

  // Operand read: address 0 is the hardwired zero register
  always_comb begin
    rd_a = (in_rs1 == '0) ? 16'h0000 : rf_q[in_rs1];
    rd_b = (in_rs2 == '0) ? 16'h0000 : rf_q[in_rs2];
  end

  // RF write arbitration: writeback in EXEC, preload only in IDLE; writes to entry 0 are dropped
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = 16'h0000;
    if (cap_en) begin
      rf_we    = (rd_q != '0);
      rf_waddr = rd_q;
      rf_wdata = alu_c;
    end else if (in_ready && ld_en) begin
      rf_we    = (ld_addr != '0);
      rf_waddr = ld_addr;
      rf_wdata = ld_data;
    end
  end

  // Register file storage; operands are fetched from the pre-write contents on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= 16'h0000;
      end
    end else if (rf_we) begin
      rf_q[rf_waddr] <= rf_wdata;
    end
  end

  // Issue registers: loaded only on accept so the ALU inputs stay put until the next instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_q  <= 16'h0000;
      alu_b_q  <= 16'h0000;
      alu_op_q <= 3'd0;
      rd_q     <= '0;
    end else if (accept) begin
      alu_a_q  <= rd_a;
      alu_b_q  <= rd_b;
      alu_op_q <= in_op;
      rd_q     <= in_rd;
    end
  end

  assign alu_a  = alu_a_q;
  assign alu_b  = alu_b_q;
  assign alu_op = alu_op_q;

  // Result capture at the end of EXEC; held through RESP regardless of out_ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= 16'h0000;
    end else if (cap_en) begin
      result_q <= alu_c;
    end
  end

  assign out_result = result_q;

`ifdef ALU_SEQ_FLAGS_EN
  logic [3:0] flags_q;
  logic [3:0] flags_d;

  // Flag slice select: add/sub for ops 0-1, bitwise for 2-4, shift for 5-7
  always_comb begin
    flags_d = {alu_zero[0], alu_negative[0], alu_overflow[0], alu_cout[0]};
    if (alu_op_q >= 3'd5) begin
      flags_d = {alu_zero[2], alu_negative[2], alu_overflow[2], alu_cout[2]};
    end else if (alu_op_q >= 3'd2) begin
      flags_d = {alu_zero[1], alu_negative[1], alu_overflow[1], alu_cout[1]};
    end
  end

  // Flag capture alongside the result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= 4'b0000;
    end else if (cap_en) begin
      flags_q <= flags_d;
    end
  end

  assign out_flags = flags_q;
`else
  // Flags are not reported in this build; the ALU flag inputs are intentionally left unused
  logic unused_flags;
  assign unused_flags = ^{alu_cout, alu_overflow, alu_negative, alu_zero};
  assign out_flags    = 4'b0000;
`endif

endmodule
